// File: rtl/adc_fifo_pkg.sv
// Shared widths, depth derivation and the registered status bundle for the ADC stream FIFO.
package adc_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 9;

  // Wide enough for the level of any FIFO up to ADDR_WIDTH = 16.
  localparam int LEVEL_MAX_W = 17;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [LEVEL_MAX_W-1:0] level;
  } fifo_status_t;

endpackage

// File: rtl/adc_fifo_ram.sv
// Simple dual-port sample store: one write port, registered read address with enable,
// and write-to-read forwarding when both ports hit the same word on the same edge.
module adc_fifo_ram
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr_q;

  // NOTE: the array has no reset; the FIFO pointers alone decide which words are live.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) raddr_q <= raddr_i;
  end

  assign rdata_o = (we_i && (waddr_i == raddr_q)) ? wdata_i : mem[raddr_q];

endmodule

// File: rtl/adc_stream_fifo.sv
// First-word-fall-through ADC sample FIFO with programmable almost-full/almost-empty flags.
// Define ADC_FIFO_ERR_FLAGS_EN to build the sticky ovf/udf flags and their err_clr.
module adc_stream_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_TWO = ADDR_WIDTH'(2);

  fifo_status_t          stat_q, stat_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
  logic [DATA_WIDTH-1:0] q_q, q_d, ram_rdata;
  logic                  pend_q, pend_d, empty_d;
  logic                  push, pop, fetch_start, ram_we, ram_re;
  logic                  unused_level_hi;

  assign level_q         = stat_q.level[ADDR_WIDTH:0];
  assign unused_level_hi = ^stat_q.level;

  assign push        = we && !stat_q.full;
  assign pop         = re && !stat_q.empty;
  // Words stored but no head on q: address the oldest word now, load q next edge.
  assign fetch_start = stat_q.empty && !pend_q && (level_q != '0);
  assign ram_we      = push && !reset;
  assign ram_re      = (fetch_start || pend_q || pop) && !reset;

  adc_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(d),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    level_d   = level_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    q_d       = q_q;
    empty_d   = stat_q.empty;
    pend_d    = fetch_start;
    ram_raddr = rd_ptr_q + PTR_TWO;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;

    if (fetch_start) ram_raddr = rd_ptr_q;
    else if (pend_q) ram_raddr = rd_ptr_q + PTR_ONE;

    // While q is valid the RAM address register already points at the word behind it.
    if (pend_q) begin
      q_d     = ram_rdata;
      empty_d = 1'b0;
    end else if (pop) begin
      if ((level_q > LVL_ONE) || push) q_d = ram_rdata;
      else                             empty_d = 1'b1;
    end

    stat_d.level        = LEVEL_MAX_W'(level_d);
    stat_d.full         = (level_d == DEPTH);
    stat_d.almost_full  = (level_d >= afull_thresh);
    stat_d.almost_empty = (level_d <= aempty_thresh);
    stat_d.empty        = empty_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q   <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1, level: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_q      <= '0;
      pend_q   <= 1'b0;
    end else begin
      stat_q   <= stat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_q      <= q_d;
      pend_q   <= pend_d;
    end
  end

  assign q            = q_q;
  assign full         = stat_q.full;
  assign empty        = stat_q.empty;
  assign level        = level_q;
  assign almost_full  = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;

`ifdef ADC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // A new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (we && stat_q.full)  || (ovf_q && !err_clr);
      udf_q <= (re && stat_q.empty) || (udf_q && !err_clr);
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ovf            = 1'b0;
  assign udf            = 1'b0;
`endif

endmodule

// File: tb/tb_adc_stream_fifo.sv
// Self-checking bench for adc_stream_fifo (ADDR_WIDTH=4) against a queue-based reference model.
module tb_adc_stream_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef ADC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, we, re, err_clr;
  logic [DW-1:0] d, q;
  logic          full, empty, almost_full, almost_empty, ovf, udf;
  logic [AW:0]   level, afull_thresh, aempty_thresh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .d            (d),
    .re           (re),
    .q            (q),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .afull_thresh (afull_thresh),
    .aempty_thresh(aempty_thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .udf          (udf),
    .err_clr      (err_clr)
  );

  // Reference model: the stored words in order, plus when the head becomes visible.
  logic [DW-1:0] mq[$];
  int            cyc = 0;
  int            vis_cyc = 0;
  logic [DW-1:0] m_q = '0;
  bit            m_ovf, m_udf, m_af, m_ae;

  function automatic bit m_empty();
    return !((mq.size() > 0) && (cyc >= vis_cyc));
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] dv, input bit r,
                      input bit clr = 1'b0, input bit rst = 1'b0);
    bit was_empty, was_full, acc_w, acc_r;
    int n0;
    we = w; d = dv; re = r; err_clr = clr; reset = rst;
    was_empty = m_empty();
    was_full  = (mq.size() == DEPTH);
    n0        = mq.size();
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_q = '0; m_ovf = 1'b0; m_udf = 1'b0; m_af = 1'b0; m_ae = 1'b1;
    end else begin
      acc_r = r && !was_empty;
      acc_w = w && !was_full;
      if (acc_r) void'(mq.pop_front());
      if (acc_w) mq.push_back(dv);
      // A word written into an empty FIFO reaches q two edges later.
      if (acc_w && n0 == 0) vis_cyc = cyc + 2;
      m_af = (mq.size() >= int'(afull_thresh));
      m_ae = (mq.size() <= int'(aempty_thresh));
      if (ERR_EN) begin
        m_ovf = (w && was_full)  || (m_ovf && !clr);
        m_udf = (r && was_empty) || (m_udf && !clr);
      end
      if (!m_empty()) m_q = mq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    afull_thresh = 5'd12; aempty_thresh = 5'd2;
    step(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (level !== 5'd0)       begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)        begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
    checks++; if (ovf !== 1'b0)         begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (udf !== 1'b0)         begin errors++; $display("FAIL reset_udf got=%b exp=0", udf); end
    checks++; if (q !== 16'h0000)       begin errors++; $display("FAIL reset_q got=%h exp=0000", q); end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_first_word();
    step(1'b1, 16'h0001, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_word_e0_empty got=%b exp=1", empty); end
    checks++; if (int'(level) != 1) begin errors++; $display("FAIL first_word_level got=%0d exp=1", level); end
    step(1'b0, '0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_word_e1_empty got=%b exp=1", empty); end
    step(1'b0, '0, 1'b0);
    checks++; if (empty !== 1'b0)   begin errors++; $display("FAIL first_word_e2_empty got=%b exp=0", empty); end
    checks++; if (q !== 16'h0001)   begin errors++; $display("FAIL first_word_e2_q got=%h exp=0001", q); end
    step(1'b0, '0, 1'b1);
    checks++; if (empty !== 1'b1 || int'(level) != 0)
      begin errors++; $display("FAIL first_word_pop got empty=%b level=%0d exp empty=1 level=0", empty, level); end
  endtask

  task automatic test_fill_drain();
    afull_thresh = 5'd12; aempty_thresh = 5'd2;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(16'h0100 + i), 1'b0);
      checks++; if (int'(level) != i + 1)
        begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, i + 1); end
      checks++; if (almost_empty !== (i + 1 <= 2))
        begin errors++; $display("FAIL fill_aempty level=%0d got=%b exp=%b", i + 1, almost_empty, (i + 1 <= 2)); end
      checks++; if (almost_full !== (i + 1 >= 12))
        begin errors++; $display("FAIL fill_afull level=%0d got=%b exp=%b", i + 1, almost_full, (i + 1 >= 12)); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    step(1'b1, 16'hDEAD, 1'b0);
    checks++; if (int'(level) != DEPTH) begin errors++; $display("FAIL ovf_level got=%0d exp=%0d", level, DEPTH); end
    checks++; if (ovf !== ERR_EN)       begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ovf, ERR_EN); end
    checks++; if (q !== 16'h0100)       begin errors++; $display("FAIL full_head got=%h exp=0100", q); end
    step(1'b1, 16'hBEEF, 1'b1);
    checks++; if (int'(level) != DEPTH - 1 || full !== 1'b0)
      begin errors++; $display("FAIL full_wr_rd got level=%0d full=%b exp level=%0d full=0", level, full, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) begin
      checks++; if (q !== DW'(16'h0100 + i))
        begin errors++; $display("FAIL drain_q got=%h exp=%h", q, DW'(16'h0100 + i)); end
      step(1'b0, '0, 1'b1);
    end
    checks++; if (empty !== 1'b1 || int'(level) != 0)
      begin errors++; $display("FAIL drain_end got empty=%b level=%0d exp empty=1 level=0", empty, level); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] sb[$];
    logic [DW-1:0] dv;
    for (int i = 0; i < 3; i++) begin
      dv = DW'($urandom);
      sb.push_back(dv);
      step(1'b1, dv, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++; if (q !== sb[0]) begin errors++; $display("FAIL b2b_q i=%0d got=%h exp=%h", i, q, sb[0]); end
      dv = DW'($urandom);
      sb.push_back(dv);
      void'(sb.pop_front());
      step(1'b1, dv, 1'b1);
      checks++; if (int'(level) != 3) begin errors++; $display("FAIL b2b_level i=%0d got=%0d exp=3", i, level); end
    end
    while (sb.size() > 0) begin
      checks++; if (q !== sb[0]) begin errors++; $display("FAIL b2b_tail got=%h exp=%h", q, sb[0]); end
      void'(sb.pop_front());
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] hold;
    step(1'b0, '0, 1'b0, 1'b1);
    hold = m_q;
    step(1'b0, '0, 1'b1);
    checks++; if (udf !== ERR_EN) begin errors++; $display("FAIL udf_set got=%b exp=%b", udf, ERR_EN); end
    checks++; if (q !== hold || empty !== 1'b1)
      begin errors++; $display("FAIL udf_q got q=%h empty=%b exp q=%h empty=1", q, empty, hold); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clr got=%b exp=0", udf); end
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (udf !== ERR_EN) begin errors++; $display("FAIL udf_set_wins got=%b exp=%b", udf, ERR_EN); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h0700 + i), 1'b0);
    checks++; if (int'(level) != 7) begin errors++; $display("FAIL flush_pre_level got=%0d exp=7", level); end
    step(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1);
    checks++; if (int'(level) != 0 || empty !== 1'b1)
      begin errors++; $display("FAIL flush_reset got level=%0d empty=%b exp level=0 empty=1", level, empty); end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (int'(level) != 0 || empty !== 1'b1)
      begin errors++; $display("FAIL flush_no_store got level=%0d empty=%b exp level=0 empty=1", level, empty); end
    step(1'b1, 16'h0042, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (q !== 16'h0042 || int'(level) != 1 || empty !== 1'b0)
      begin errors++; $display("FAIL flush_after got q=%h level=%0d empty=%b exp q=0042 level=1 empty=0", q, level, empty); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [DW+AW+6:0] act, exp;
    logic [AW:0]      el;
    int               wp, rp;
    for (int ph = 0; ph < 6; ph++) begin
      afull_thresh  = (AW+1)'($urandom_range(DEPTH));
      aempty_thresh = (AW+1)'($urandom_range(DEPTH));
      wp = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 55);
      rp = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 85 : 55);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < rp,
             $urandom_range(19) == 0, $urandom_range(149) == 0);
        el  = (AW+1)'(mq.size());
        act = {q, empty, full, level, almost_full, almost_empty, ovf, udf};
        exp = {m_q, m_empty(), mq.size() == DEPTH, el, m_af, m_ae, m_ovf, m_udf};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL random cyc=%0d {q,empty,full,level,af,ae,ovf,udf} got=%h exp=%h", cyc, act, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; err_clr = 1'b0; d = '0;
    afull_thresh = 5'd12; aempty_thresh = 5'd2;
    test_reset();
    test_first_word();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/adc_stream_fifo.md
ADC_STREAM_FIFO -- requirements
Module: adc_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning sample word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning log2 of storage depth; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port we  input  1  write request.
REQ-006 SHALL have port d  input  DATA_WIDTH  write data.
REQ-007 SHALL have port re  input  1  read request (pop of the word currently on q).
REQ-008 SHALL have port q  output  DATA_WIDTH  head-of-queue data (first-word-fall-through).
REQ-009 SHALL have ports full and empty, each output 1, meaning no space / no valid head word.
REQ-010 SHALL have port level  output  ADDR_WIDTH+1  count of stored words.
REQ-011 SHALL have ports afull_thresh and aempty_thresh, each input ADDR_WIDTH+1, meaning programmable thresholds.
REQ-012 SHALL have ports almost_full and almost_empty, each output 1, meaning threshold flags.
REQ-013 SHALL have ports ovf and udf (output 1, sticky error flags) and err_clr (input 1, flag clear).

Function
REQ-014 SHALL accept a write when we && !full; a write while full is dropped, storage and pointers unchanged.
REQ-015 SHALL accept a read when re && !empty; re while empty is ignored.
REQ-016 SHALL present a word written at edge N on q, with empty low, from edge N+2 when the FIFO was empty.
REQ-017 SHALL, after an accepted read at edge N, present the next stored word on q from edge N+1 with no bubble while level > 1.
REQ-018 SHALL resolve a same-address write/read collision by forwarding d, never returning stale RAM data.
REQ-019 SHALL increment level on accepted write only, decrement on accepted read only, hold on both or neither; updated at the accepting edge.
REQ-020 SHALL drive full = (level == DEPTH), almost_full = (level >= afull_thresh), almost_empty = (level <= aempty_thresh), all registered consistently with level.
REQ-021 SHALL wrap read and write pointers modulo DEPTH without gap; full uses all DEPTH words.
REQ-022 SHALL, with full asserted and we && re both high, accept the read and drop the write (ovf set).
REQ-023 SHALL set ovf on we && full, set udf on re && empty; err_clr clears both; a set in the same cycle as err_clr wins.
REQ-024 SHALL hold q stable while empty is high and while re is low.

Reset
REQ-025 SHALL on reset clear pointers, level=0, empty=1, full=0, almost_full=0, almost_empty=1, ovf=0, udf=0, q=0.
REQ-026 SHALL treat reset asserted mid-stream as a flush: all stored words discarded, any in-flight read/write that cycle ignored, RAM contents not cleared.

Configuration
REQ-027 SHALL compile ovf/udf/err_clr logic only when macro ADC_FIFO_ERR_FLAGS_EN is defined; without it ovf and udf SHALL be tied 0, err_clr unused, all other behaviour identical.

Structure
REQ-028 SHALL place default widths, the DEPTH derivation function and a fifo-status struct (full, empty, almost_full, almost_empty, level) in package adc_fifo_pkg.
REQ-029 SHALL instantiate storage as sub-module adc_fifo_ram: simple dual-port, one write port, registered read address, read-enable input.

Verification
REQ-030 Reset, then write 0x0001 at edge 0 -> empty low and q=0x0001 from edge 2, level=1.
REQ-031 ADDR_WIDTH=4: write 16 words 0x0100..0x010F -> full=1, level=16; 17th write 0xDEAD -> dropped, ovf=1; drain -> 0x0100..0x010F in order, empty=1.
REQ-032 Continuous simultaneous we/re at level 3 for 40 cycles across pointer wrap -> level stays 3, output order matches input order.
REQ-033 afull_thresh=12, aempty_thresh=2: fill 0->13 -> almost_empty drops at level 3, almost_full rises at level 12.
REQ-034 re on empty FIFO -> udf=1, q unchanged; err_clr pulse -> udf=0; err_clr with re-on-empty same cycle -> udf stays 1.
REQ-035 reset asserted at level 7 with we high -> next cycle level=0, empty=1, write not stored.
